// File: rtl/sipo_rx.sv
// ============================================================================
// Module  : sipo_rx
// Brief   : LSB-first serial-to-parallel receiver with a ready/valid output
//           register and a sticky overrun flag.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sipo_rx #(
  parameter int WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     si,
  input  logic                     si_valid,
  input  logic                     clr,
  output logic [WIDTH-1:0]         po,
  output logic                     po_valid,
  input  logic                     po_ready,
  output logic [$clog2(WIDTH):0]   bit_cnt,
  output logic                     overrun
);

  localparam int               c_CW   = $clog2(WIDTH) + 1;
  localparam logic [c_CW-1:0]  c_LAST = c_CW'(WIDTH - 1);

  logic [WIDTH-1:0] r_shift;
  logic [c_CW-1:0]  r_cnt;
  logic [WIDTH-1:0] r_po;
  logic             r_po_valid;
  logic             r_overrun;

  logic [WIDTH-1:0] w_shift_nxt;
  logic             w_accept;
  logic             w_done;
  logic             w_free;
  logic             w_xfer;

  // New bits enter at the top so the first bit ends up in bit 0.
  assign w_shift_nxt = {si, r_shift[WIDTH-1:1]};
  assign w_accept    = si_valid && !clr;
  assign w_done      = w_accept && (r_cnt == c_LAST);
  assign w_xfer      = r_po_valid && po_ready;
  assign w_free      = !r_po_valid || po_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (clr) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_shift <= w_shift_nxt;
      r_cnt   <= w_done ? '0 : r_cnt + c_CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_po       <= '0;
      r_po_valid <= 1'b0;
    end else if (w_done && w_free) begin
      r_po       <= w_shift_nxt;
      r_po_valid <= 1'b1;
    end else if (w_xfer) begin
      r_po_valid <= 1'b0;
    end
  end

  // Sticky until clr; a completion into an occupied, stalled output drops the word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overrun <= 1'b0;
    end else if (clr) begin
      r_overrun <= 1'b0;
    end else if (w_done && !w_free) begin
      r_overrun <= 1'b1;
    end
  end

  assign po       = r_po;
  assign po_valid = r_po_valid;
  assign bit_cnt  = r_cnt;
  assign overrun  = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_sipo_rx.sv
// ============================================================================
// Module  : tb_sipo_rx
// Brief   : Self-checking bench for sipo_rx against an index-based word model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sipo_rx;

  localparam int WIDTH = 4;

  logic             clk;
  logic             rst_n;
  logic             si;
  logic             si_valid;
  logic             clr;
  logic             po_ready;
  logic [WIDTH-1:0] po;
  logic             po_valid;
  logic [2:0]       bit_cnt;
  logic             overrun;

  int n_chk;
  int n_fail;

  // Reference state: bits are placed by index into the word being assembled.
  logic [WIDTH-1:0] m_word;
  int               m_cnt;
  logic [WIDTH-1:0] m_po;
  logic             m_pv;
  logic             m_ovr;

  sipo_rx #(.WIDTH(WIDTH)) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .si       (si),
    .si_valid (si_valid),
    .clr      (clr),
    .po       (po),
    .po_valid (po_valid),
    .po_ready (po_ready),
    .bit_cnt  (bit_cnt),
    .overrun  (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_word = '0;
    m_cnt  = 0;
    m_po   = '0;
    m_pv   = 1'b0;
    m_ovr  = 1'b0;
  endtask

  task automatic model_edge();
    logic xfer, free, done;
    if (!rst_n) begin
      m_reset();
      return;
    end
    xfer = m_pv && po_ready;
    free = !m_pv || po_ready;
    done = 1'b0;
    if (clr) begin
      m_word = '0;
      m_cnt  = 0;
      m_ovr  = 1'b0;
    end else if (si_valid) begin
      m_word[m_cnt] = si;
      m_cnt++;
      if (m_cnt == WIDTH) begin
        done  = 1'b1;
        m_cnt = 0;
      end
    end
    if (xfer) m_pv = 1'b0;
    if (done) begin
      if (free) begin
        m_po = m_word;
        m_pv = 1'b1;
      end else begin
        m_ovr = 1'b1;
      end
      m_word = '0;
    end
  endtask

  task automatic check_all();
    check("po",       32'(po),       32'(m_po));
    check("po_valid", 32'(po_valid), 32'(m_pv));
    check("bit_cnt",  32'(bit_cnt),  32'(m_cnt));
    check("overrun",  32'(overrun),  32'(m_ovr));
  endtask

  // One clock: model follows the edge, outputs compared 1 time unit later.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic send_word(input logic [WIDTH-1:0] w, input int gap);
    for (int i = 0; i < WIDTH; i++) begin
      si       = w[i];
      si_valid = 1'b1;
      step();
      si_valid = 1'b0;
      for (int g = 0; g < gap; g++) step();
    end
  endtask

  task automatic drain();
    po_ready = 1'b1;
    step();
    po_ready = 1'b0;
  endtask

  initial begin
    n_chk    = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    si       = 1'b0;
    si_valid = 1'b0;
    clr      = 1'b0;
    po_ready = 1'b0;
    m_reset();
    step();
    step();
    #2 rst_n = 1'b1;

    // Basic word 1010 with bit_cnt sequence 1,2,3,0
    for (int i = 0; i < WIDTH; i++) begin
      si       = 1'(4'b1010 >> i);
      si_valid = 1'b1;
      step();
      check("basic_cnt", 32'(bit_cnt), 32'((i + 1) % WIDTH));
    end
    si_valid = 1'b0;
    check("basic_po", 32'(po), 32'h0000_000A);
    check("basic_pv", 32'(po_valid), 32'h1);
    drain();

    // Gapped stream
    send_word(4'b1010, 2);
    check("gap_po", 32'(po), 32'h0000_000A);
    drain();

    // Back-to-back streaming with consumer always ready
    po_ready = 1'b1;
    send_word(4'b1010, 0);
    send_word(4'b0110, 0);
    check("stream_po", 32'(po), 32'h6);
    check("stream_ovr", 32'(overrun), 32'h0);
    step();
    po_ready = 1'b0;

    // Overrun, then clr leaves the output intact
    send_word(4'b1010, 0);
    send_word(4'b1111, 0);
    check("ovr_po", 32'(po), 32'hA);
    check("ovr_flag", 32'(overrun), 32'h1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("clr_ovr", 32'(overrun), 32'h0);
    check("clr_po", 32'(po), 32'hA);
    check("clr_pv", 32'(po_valid), 32'h1);
    drain();

    // clr mid-word with a simultaneous valid bit
    send_word(4'b0011, 0);
    drain();
    si = 1'b1; si_valid = 1'b1;
    step(); step();
    clr = 1'b1;
    step();
    clr = 1'b0; si_valid = 1'b0;
    send_word(4'b0011, 0);
    check("clrmid_po", 32'(po), 32'h3);
    drain();

    // Asynchronous reset between edges, mid-word
    si = 1'b1; si_valid = 1'b1;
    step(); step();
    si_valid = 1'b0;
    po_ready = 1'b0;
    send_word(4'b0101, 0);
    si = 1'b1; si_valid = 1'b1;
    step();
    #2 rst_n = 1'b0;
    #1;
    m_reset();
    check("rst_po", 32'(po), 32'h0);
    check("rst_pv", 32'(po_valid), 32'h0);
    check("rst_cnt", 32'(bit_cnt), 32'h0);
    check_all();
    step(); step();
    #2 rst_n = 1'b1;
    si_valid = 1'b0;
    send_word(4'b1001, 0);
    check("post_rst_po", 32'(po), 32'h9);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      si       = 1'($urandom);
      si_valid = ($urandom_range(0, 3) != 0);
      po_ready = ($urandom_range(0, 2) != 0);
      clr      = ($urandom_range(0, 19) == 0);
      step();
    end
    clr = 1'b0; si_valid = 1'b0; po_ready = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, expected finish before 200000");
    $fatal(1);
  end

endmodule

`default_nettype wire
